spi_prot_trig: RTL
==================

Name: spi_prot_trig

Overview:
- Protocol-trigger unit for the LA digital core.
- Sits directly downstream of the channel inputs: CH1 carries SS_n, CH2 carries SCLK and CH3 carries MOSI.
- Passively snoops one SPI frame of 8 or 16 bits, MSB first, and compares it against a masked match value.
- Pulses a trigger flag into the capture/trigger logic when the frame matches.

Parameters:
- SYNC_STAGES, 3, flops in each input synchronizer chain (minimum 2).

Ports:
- clk  in  1  system clock (100MHz).
- rst  in  1  synchronous active-high reset.
- SS_n  in  1  SPI slave select, asynchronous to clk.
- SCLK  in  1  SPI clock, asynchronous.
- MOSI  in  1  SPI data, asynchronous.
- edg  in  1  1 = sample MOSI on SCLK rise; 0 = sample on SCLK fall.
- len8  in  1  1 = 8-bit frame; 0 = 16-bit frame.
- match  in  16  compare value; only [7:0] is used when len8=1.
- mask  in  16  1 in a bit position = don't care.
- SPItrig  out  1  one-clk pulse on a matching frame.
- rx_data  out  16  last completed frame; zero-extended when len8=1.
- rx_vld  out  1  one-clk pulse for every length-valid frame, matching or not.

Behaviour:
- Reset: one clock with rst=1 forces all outputs to 0.
  - rx_data=0, SPItrig=0, rx_vld=0.
  - State=IDLE, bit_cnt=0, shift register=0.
  - Synchronizer flops preset to 1 (SS_n, SCLK) and 0 (MOSI), so no false edge appears after reset.
- Synchronization:
  - SS_n, SCLK and MOSI each pass through SYNC_STAGES flops.
  - One extra flop per signal provides the previous-value term for edge detection.
  - MOSI is taken from the same synchronizer depth as SCLK, so data and edge stay aligned.
- Edge detect:
  - sclk_rise = cur & ~prev; sclk_fall = ~cur & prev.
  - smpl = edg ? sclk_rise : sclk_fall.
  - ss_fall and ss_rise are derived the same way from SS_n.
- FSM has two states, IDLE and RX.
  - IDLE: on ss_fall, go to RX and clear bit_cnt and the shift register. SCLK edges are ignored in IDLE.
  - RX, smpl=1 and SS_n low: shift = {shift[14:0], MOSI_sync}, and bit_cnt increments.
  - bit_cnt is 5 bits and saturates at 31; it never wraps.
  - RX, ss_rise: go to IDLE and evaluate the frame.
  - The frame is length-valid only if bit_cnt equals 8 (len8=1) or 16 (len8=0).
  - A length-valid frame updates rx_data and pulses rx_vld, and pulses SPItrig if it matches.
  - A short or over-long frame changes nothing and produces no pulses.
- Match rule:
  - 16-bit: ((shift ^ match) & ~mask) == 0.
  - 8-bit: the same rule on [7:0] only.
- Latency: SPItrig and rx_vld assert in the clk cycle after the cycle in which ss_rise is detected, and are high for exactly one clk.
- Simultaneous events:
  - smpl and ss_rise in the same cycle: the edge is not shifted, because SS_n already reads high.
  - ss_fall while already in RX cannot occur and needs no handling.
- edg, len8, match and mask are quasi-static.
  - They are sampled combinationally at evaluation time.
  - A change mid-frame affects only that frame's evaluation.
- rst mid-frame: the frame is abandoned and the block returns to IDLE.
  - An SS_n that is already low after reset is not a frame start; the block waits for the next ss_fall.
- Input bandwidth: SCLK half-period must be at least 2 clk, so each edge is seen exactly once.

Test Plan:
- 8-bit match, falling edge: len8=1, edg=0, match=16'h0066, mask=0; send 0x66 with SCLK=clk/32.
  - Expect one SPItrig pulse and one rx_vld pulse; rx_data=16'h0066.
- 8-bit mismatch: same setup, send 0x96.
  - Expect rx_vld pulse, rx_data=16'h0096, and no SPItrig.
- Masked 16-bit, rising edge: len8=0, edg=1, match=16'hAB00, mask=16'h00FF; send 16'hAB5C.
  - Expect SPItrig.
  - Then send 16'hAC5C; expect no SPItrig, rx_data=16'hAC5C.
- Short frame: len8=0; drop SS_n, clock only 12 bits, raise SS_n.
  - Expect no rx_vld and no SPItrig; rx_data holds its prior value.
- Over-long frame: len8=1; send 9 bits.
  - Expect no pulses, and bit_cnt stays correct when a following valid frame triggers normally.
- Reset mid-frame: assert rst for 1 clk after 5 bits of a matching 0x66 frame.
  - Expect all outputs 0 and no trigger when SS_n later rises.
  - A subsequent full 0x66 frame triggers exactly once.

Source files
------------

// File: rtl/spi_prot_trig.sv
`default_nettype none
// ============================================================================
// Module      : spi_prot_trig
// Description : SPI protocol trigger for the LA digital core. Passively snoops
//               one 8- or 16-bit MSB-first SPI frame on CH1 (SS_n), CH2 (SCLK)
//               and CH3 (MOSI). It compares the frame against a masked match
//               value and pulses SPItrig when the frame matches.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_prot_trig #(
    parameter int SYNC_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        edg,
    input  logic        len8,
    input  logic [15:0] match,
    input  logic [15:0] mask,
    output logic        SPItrig,
    output logic [15:0] rx_data,
    output logic        rx_vld
);

    // Cycles after reset before an SS_n fall may be trusted. The preset value
    // must first be flushed out of the synchronizer and the previous-value flop.
    localparam int                  c_FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_INIT = c_FLUSH_W'(SYNC_STAGES + 1);
    localparam logic [4:0]          c_CNT_MAX    = 5'd31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_prev;
    logic                   r_sclk_prev;
    logic [c_FLUSH_W-1:0]   r_flush;

    state_t                 r_state;
    logic [4:0]             r_bit_cnt;
    logic [15:0]            r_shift;
    logic [15:0]            r_rx_data;
    logic                   r_trig;
    logic                   r_vld;

    logic                   w_ss_cur;
    logic                   w_sclk_cur;
    logic                   w_mosi_cur;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_smpl;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic [15:0]            w_diff;
    logic                   w_hit;
    logic                   w_len_ok;

    // Input synchronizers. SS_n and SCLK are preset to their idle-high level
    // and MOSI to 0. MOSI uses the same depth as SCLK so data and edge stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '1;
            r_mosi_sync <= '0;
            r_ss_prev   <= 1'b1;
            r_sclk_prev <= 1'b1;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    // Post-reset blanking so that an SS_n already low at reset is not taken as a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush <= c_FLUSH_INIT;
        end else if (r_flush != '0) begin
            r_flush <= r_flush - 1'b1;
        end
    end

    assign w_ss_cur    = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_cur  = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_cur  = r_mosi_sync[SYNC_STAGES-1];

    assign w_sclk_rise = w_sclk_cur & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_cur & r_sclk_prev;
    assign w_smpl      = edg ? w_sclk_rise : w_sclk_fall;
    assign w_ss_fall   = ~w_ss_cur & r_ss_prev & (r_flush == '0);
    assign w_ss_rise   = w_ss_cur & ~r_ss_prev;

    // Masked compare. In 8-bit mode only the low byte takes part.
    assign w_diff      = (r_shift ^ match) & ~mask;
    assign w_hit       = len8 ? (w_diff[7:0] == 8'h00) : (w_diff == 16'h0000);
    assign w_len_ok    = len8 ? (r_bit_cnt == 5'd8) : (r_bit_cnt == 5'd16);

    // Frame receive FSM. It collects bits while SS_n is low and evaluates the frame on SS_n rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'h0000;
            r_rx_data <= 16'h0000;
            r_trig    <= 1'b0;
            r_vld     <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            r_vld  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= ST_RX;
                        r_bit_cnt <= 5'd0;
                        r_shift   <= 16'h0000;
                    end
                end
                ST_RX: begin
                    if (w_ss_rise) begin
                        r_state <= ST_IDLE;
                        if (w_len_ok) begin
                            r_rx_data <= len8 ? {8'h00, r_shift[7:0]} : r_shift;
                            r_vld     <= 1'b1;
                            r_trig    <= w_hit;
                        end
                    end else if (w_smpl && !w_ss_cur) begin
                        r_shift <= {r_shift[14:0], w_mosi_cur};
                        if (r_bit_cnt != c_CNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign SPItrig = r_trig;
    assign rx_vld  = r_vld;
    assign rx_data = r_rx_data;

endmodule
`default_nettype wire
